// File: rtl/scoreboard_hazard_if.sv
// rtl/scoreboard_hazard_if.sv - decode-stage issue bundle between datapath and hazard unit
// Ports (master = decode stage drives, slave = hazard unit):
//   issue_valid, issue_srca, issue_srcb, issue_uses_b, issue_branch,
//   issue_wen, issue_wreg, issue_load, issue_mdu, issue_rd_hilo  (master -> slave)
//   issue_fire                                                   (slave -> master)
interface scoreboard_hazard_if #(
  parameter int AW = 5
);
  logic          issue_valid;
  logic [AW-1:0] issue_srca;
  logic [AW-1:0] issue_srcb;
  logic          issue_uses_b;
  logic          issue_branch;
  logic          issue_wen;
  logic [AW-1:0] issue_wreg;
  logic          issue_load;
  logic          issue_mdu;
  logic          issue_rd_hilo;
  logic          issue_fire;

  modport master (
    output issue_valid, issue_srca, issue_srcb, issue_uses_b, issue_branch,
           issue_wen, issue_wreg, issue_load, issue_mdu, issue_rd_hilo,
    input  issue_fire
  );

  modport slave (
    input  issue_valid, issue_srca, issue_srcb, issue_uses_b, issue_branch,
           issue_wen, issue_wreg, issue_load, issue_mdu, issue_rd_hilo,
    output issue_fire
  );
endinterface

// File: rtl/scoreboard_hazard.sv
// rtl/scoreboard_hazard.sv - countdown-scoreboard hazard unit for the five-stage pipeline
// Optional feature macro: HAZARD_STATS_EN (adds perf_dep_stall dependency-stall cycle counter)
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   iss                 decode issue bundle (slave modport), returns issue_fire
//   i_data_ok/d_data_ok instruction/data memory response ready
//   exception_valid     exception committing
//   is_eret             eret committing
//   stallF..stallM      stage holds
//   flushD..flushW      stage bubble inserts
//   mdu_busy            HI/LO not yet readable
//   perf_dep_stall      (HAZARD_STATS_EN only) saturating count of dependency-stall cycles
module scoreboard_hazard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 2,
  parameter int BR_LAT   = 1,
  parameter int MDU_LAT  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  scoreboard_hazard_if.slave   iss,
  input  logic                 i_data_ok,
  input  logic                 d_data_ok,
  input  logic                 exception_valid,
  input  logic                 is_eret,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 stallE,
  output logic                 stallM,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 flushM,
  output logic                 flushW,
  output logic                 mdu_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          perf_dep_stall
`endif
);

  localparam int LB_MAX  = (LOAD_LAT > BR_LAT) ? LOAD_LAT : BR_LAT;
  localparam int MAX_LAT = (LB_MAX > MDU_LAT) ? LB_MAX : MDU_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [NREG-1:0] ld_q;
  logic [NREG-1:0] ld_d;
  logic [CW-1:0]   mdu_cnt_q;
  logic [CW-1:0]   mdu_cnt_d;

  logic flush_ex;
  logic haz_a;
  logic haz_b;
  logic dep_stall;
  logic fire;

  // Hazard detection: a pending load result blocks any reader, a pending
  // ALU result only blocks a branch that resolves in decode.
  always_comb begin
    flush_ex = exception_valid | is_eret;
    haz_a = (iss.issue_srca != '0) && (cnt_q[iss.issue_srca] != '0) &&
            (ld_q[iss.issue_srca] || iss.issue_branch);
    haz_b = (iss.issue_srcb != '0) && (cnt_q[iss.issue_srcb] != '0) &&
            (ld_q[iss.issue_srcb] || iss.issue_branch);
    mdu_busy  = (mdu_cnt_q != '0);
    dep_stall = iss.issue_valid &
                (haz_a | (iss.issue_uses_b & haz_b) |
                 ((iss.issue_rd_hilo | iss.issue_mdu) & mdu_busy));
  end

  always_comb begin
    stallF = ~i_data_ok | ~d_data_ok | dep_stall;
    stallD = stallF;
    stallE = ~d_data_ok;
    stallM = ~d_data_ok;
    flushD = flush_ex;
    flushE = flush_ex | (d_data_ok & (dep_stall | ~i_data_ok));
    flushM = flush_ex;
    flushW = flush_ex | ~d_data_ok;
    fire   = iss.issue_valid & ~stallD & ~flush_ex;
    iss.issue_fire = fire;
  end

  // Next-state for the scoreboard. Order matters: decrement, then a new
  // issue overrides that register, then an exception wipes everything.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      ld_d[r]  = ld_q[r];
      // Register results arrive through the memory pipeline, so they
      // freeze while the data side is stalled.
      if (d_data_ok && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
      if (cnt_d[r] == '0) begin
        ld_d[r] = 1'b0;
      end
    end

    if (fire && iss.issue_wen && (iss.issue_wreg != '0)) begin
      cnt_d[iss.issue_wreg] = iss.issue_load ? CW'(LOAD_LAT) : CW'(BR_LAT);
      ld_d[iss.issue_wreg]  = iss.issue_load;
    end

    // The MDU runs on its own, independent of memory stalls.
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - CW'(1);
    end
    if (fire && iss.issue_mdu) begin
      mdu_cnt_d = CW'(MDU_LAT);
    end

    if (flush_ex) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = '0;
        ld_d[r]  = 1'b0;
      end
      mdu_cnt_d = '0;
    end

    // $0 is hard-wired zero and never tracked.
    cnt_d[0] = '0;
    ld_d[0]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      ld_q      <= '0;
      mdu_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      ld_q      <= ld_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] perf_dep_stall_q;
  logic [31:0] perf_dep_stall_d;

  always_comb begin
    perf_dep_stall_d = perf_dep_stall_q;
    if (dep_stall && (perf_dep_stall_q != 32'hFFFF_FFFF)) begin
      perf_dep_stall_d = perf_dep_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dep_stall_q <= '0;
    end else begin
      perf_dep_stall_q <= perf_dep_stall_d;
    end
  end

  assign perf_dep_stall = perf_dep_stall_q;
`endif

endmodule

// File: doc/scoreboard_hazard.md
# scoreboard_hazard

Parametrised hazard unit for the five-stage MIPS pipeline. It replaces fixed stage-comparison stall logic with a per-register countdown scoreboard and a separate MDU busy counter. Only instructions that actually depend on an in-flight load, ALU result or HI/LO write are stalled; independent instructions keep issuing. It sits beside the datapath, takes decode-stage operand info plus the memory handshakes and exception signals, and drives every stall and flush line.

## Interface
- NREG, 32, number of architectural GPRs tracked; register 0 is never tracked
- AW, 5, register address width ($clog2(NREG))
- LOAD_LAT, 2, cycles a load result is unavailable to a decode-stage consumer (1..7)
- BR_LAT, 1, cycles an ALU result is unavailable to a decode-stage branch/jump (0..7)
- MDU_LAT, 8, cycles from MDU issue until HI/LO is readable (1..63)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decode stage holds a valid instruction
- issue_srca / issue_srcb  in  AW  source registers
- issue_uses_b  in  1  srcb is a real operand
- issue_branch  in  1  branch or jump resolved in decode
- issue_wen / issue_wreg  in  1 / AW  instruction writes a GPR / destination
- issue_load  in  1  instruction is a load
- issue_mdu  in  1  instruction writes HI/LO (mult/div/mthi/mtlo)
- issue_rd_hilo  in  1  instruction reads HI/LO (mfhi/mflo)
- i_data_ok, d_data_ok  in  1  instruction/data memory responses ready
- exception_valid, is_eret  in  1  exception or eret committing
- stallF, stallD, stallE, stallM  out  1  stage hold
- flushD, flushE, flushM, flushW  out  1  stage bubble insert
- issue_fire  out  1  decode instruction advances into E this cycle
- mdu_busy  out  1  MDU counter non-zero

## Operation
- State: per register r in 1..NREG-1, a counter cnt[r] (width CW = $clog2(max(LOAD_LAT,BR_LAT,MDU_LAT)+1)) and a flag ld[r]. Plus one counter mdu_cnt.
- flush_ex = exception_valid | is_eret.
- A source s is hazardous when s != 0, cnt[s] != 0, and either ld[s] is set or issue_branch is set.
- dep_stall = issue_valid & (haz(srca) | (issue_uses_b & haz(srcb)) | ((issue_rd_hilo | issue_mdu) & mdu_busy)).
- stallF = stallD = ~i_data_ok | ~d_data_ok | dep_stall.
- stallE = stallM = ~d_data_ok.
- flushD = flush_ex.
- flushE = flush_ex | (d_data_ok & (dep_stall | ~i_data_ok)).
- flushM = flush_ex.
- flushW = flush_ex | ~d_data_ok.
- issue_fire = issue_valid & ~stallD & ~flush_ex.
- Update on issue_fire with issue_wen and issue_wreg != 0:
  - Load: cnt = LOAD_LAT, ld = 1.
  - Otherwise: cnt = BR_LAT, ld = 0.
  - Issue updates take priority over that register's decrement in the same cycle.
- On issue_fire with issue_mdu: mdu_cnt = MDU_LAT.
- Register counters decrement by 1 per cycle only while d_data_ok = 1. They saturate at 0, and ld clears when cnt reaches 0.
- mdu_cnt decrements every cycle regardless of d_data_ok, because the MDU runs independently.

## Timing
- All stall/flush outputs are combinational from current state and inputs. Counters are registered, so they take effect on the cycle after issue.
- A consumer immediately behind a load stalls exactly LOAD_LAT cycles (with d_data_ok held high).
- A branch behind an ALU producer stalls BR_LAT cycles. A non-branch consumer behind an ALU producer never stalls.
- flush_ex clears all cnt, ld and mdu_cnt on the next edge and overrides a same-cycle issue: no scoreboard update.
- reset clears all state. Outputs after reset: every stall = 0 when i_data_ok = d_data_ok = 1, all flushes = 0, mdu_busy = 0.
- The same register written by back-to-back issues: the latest issue's value wins.

## Configuration
- HAZARD_STATS_EN:
  - When defined, adds output perf_dep_stall (32-bit, saturating at 0xFFFFFFFF). It counts cycles with dep_stall = 1 and is cleared by reset.
  - When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- lw $3 then addu $4,$3,$0 (LOAD_LAT=2) -> stallD high 2 cycles, flushE high 2 cycles, issue_fire on cycle 3.
- addu $5 then beq $5,$0 (BR_LAT=1) -> one stall cycle. The same pair with an addu consumer instead of beq -> zero stall.
- mult then 3 independent addu then mflo (MDU_LAT=8) -> addu issue without stall, mflo stalls until mdu_cnt = 0, mdu_busy drops 8 cycles after the mult fires.
- lw $3 with d_data_ok low 4 cycles -> cnt[3] frozen; consumer stalls 4 + LOAD_LAT cycles, stallE = stallM = 1 during the low window.
- lw $7 issued, then exception_valid the next cycle -> all flushes high, cnt[7] = 0 after the edge, the following reader of $7 issues without stall.
- lw $0 then reader of $0 -> no stall; with the macro enabled, perf_dep_stall = 0.
